// File: rtl/stateful_alu.sv
// Stateful ALU: one action at a time through IDLE -> READ -> OUT, with a
// per-tenant windowed state RAM and an overflow error counter.
//
//   state | meaning
//   IDLE  | ready for an action; RAM read issued in the accept cycle
//   READ  | RAM data available; result and pending write computed
//   OUT   | result presented; pending write commits on ready_in handshake
module stateful_alu #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int ACTION_LEN    = 25,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ACTION_LEN-1:0]    action_in,
  input  logic                     action_valid,
  input  logic [DATA_WIDTH-1:0]    operand_1_in,
  input  logic [DATA_WIDTH-1:0]    operand_2_in,
  input  logic [DATA_WIDTH-1:0]    operand_3_in,
  input  logic [15:0]              page_tbl_in,
  output logic                     ready_out,
  output logic [DATA_WIDTH-1:0]    container_out,
  output logic                     container_out_valid,
  input  logic                     ready_in,
  output logic                     overflow_out,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, READ, OUT} state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [3:0]              opcode_in, opcode_q;
  logic [DATA_WIDTH-1:0]   op1_q, op2_q, op3_q;
  logic [ADDR_WIDTH-1:0]   index, rd_addr, addr_q;
  logic                    accept, ovf_in, ovf_q;
  logic                    wr_en_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [DATA_WIDTH-1:0]   result, wr_val, rd_inc;
  logic [DATA_WIDTH:0]     sum_c;
  logic                    wr_req;
  logic                    unused_bits;

  assign unused_bits = ^{action_in[ACTION_LEN-5:0], page_tbl_in[7:ADDR_WIDTH]};

  function automatic logic is_ram_op(input logic [3:0] op);
    case (op)
      4'b1000, 4'b0011, 4'b1011, 4'b0111, 4'b0100: is_ram_op = 1'b1;
      default:                                     is_ram_op = 1'b0;
    endcase
  endfunction

  assign ready_out = (state == IDLE);
  assign accept    = action_valid && ready_out;
  assign opcode_in = action_in[ACTION_LEN-1 -: 4];
  assign index     = operand_2_in[ADDR_WIDTH-1:0];
  // Base wraps within the RAM; window check compares the raw index to addr_len.
  assign rd_addr   = page_tbl_in[ADDR_WIDTH-1:0] + index;
  assign ovf_in    = is_ram_op(opcode_in) && (16'(index) > 16'(page_tbl_in[15:8]));

  always_comb begin
    result = op3_q;
    wr_val = op1_q;
    wr_req = 1'b0;
    sum_c  = {1'b0, op1_q} + {1'b0, op2_q};
    rd_inc = rd_data + DATA_WIDTH'(1);
    case (opcode_q)
      4'b0001, 4'b1001: result = sum_c[DATA_WIDTH-1:0];
      4'b0010, 4'b1010: result = op1_q - op2_q;
      4'b1100:          result = sum_c[DATA_WIDTH] ? '1 : sum_c[DATA_WIDTH-1:0];
      4'b0101:          result = op1_q | op2_q;
      4'b0110:          result = {{(DATA_WIDTH-1){1'b0}}, (op1_q >= op2_q)};
      4'b1110:          result = op2_q;
      4'b1000, 4'b0011: begin
        result = op3_q;
        wr_val = op1_q;
        wr_req = 1'b1;
      end
      4'b1011:          result = rd_data;
      4'b0111: begin
        result = rd_inc;
        wr_val = rd_inc;
        wr_req = 1'b1;
      end
      4'b0100: begin
        result = rd_data;
        wr_val = (rd_data == op3_q) ? '0 : rd_inc;
        wr_req = 1'b1;
      end
      default:          result = op3_q;
    endcase
    if (ovf_q) begin
      result = op3_q;
      wr_req = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      opcode_q            <= '0;
      op1_q               <= '0;
      op2_q               <= '0;
      op3_q               <= '0;
      addr_q              <= '0;
      ovf_q               <= 1'b0;
      wr_en_q             <= 1'b0;
      wr_data_q           <= '0;
      container_out       <= '0;
      container_out_valid <= 1'b0;
      overflow_out        <= 1'b0;
      err_cnt             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (action_valid) begin
            opcode_q <= opcode_in;
            op1_q    <= operand_1_in;
            op2_q    <= operand_2_in;
            op3_q    <= operand_3_in;
            addr_q   <= rd_addr;
            ovf_q    <= ovf_in;
            state    <= READ;
          end
        end
        READ: begin
          container_out       <= result;
          container_out_valid <= 1'b1;
          overflow_out        <= ovf_q;
          wr_en_q             <= wr_req;
          wr_data_q           <= wr_val;
          if (ovf_q && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
          state               <= OUT;
        end
        OUT: begin
          if (ready_in) begin
            container_out_valid <= 1'b0;
            overflow_out        <= 1'b0;
            wr_en_q             <= 1'b0;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // No reset on the array so it maps to block RAM; a reset mid-action kills the write via state.
  always_ff @(posedge clk) begin
    if ((state == OUT) && ready_in && wr_en_q) mem[addr_q] <= wr_data_q;
    if (accept) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_stateful_alu.sv
// Directed bench for stateful_alu: arithmetic, RAM ops, window overflow,
// backpressure and reset during an in-flight store.
module tb_stateful_alu;

  logic        clk;
  logic        rst;
  logic [24:0] action_in;
  logic        action_valid;
  logic [31:0] operand_1_in, operand_2_in, operand_3_in;
  logic [15:0] page_tbl_in;
  logic        ready_out;
  logic [31:0] container_out;
  logic        container_out_valid;
  logic        ready_in;
  logic        overflow_out;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] res;
  logic        ovf;
  int          lat;

  stateful_alu dut (
    .clk                 (clk),
    .rst                 (rst),
    .action_in           (action_in),
    .action_valid        (action_valid),
    .operand_1_in        (operand_1_in),
    .operand_2_in        (operand_2_in),
    .operand_3_in        (operand_3_in),
    .page_tbl_in         (page_tbl_in),
    .ready_out           (ready_out),
    .container_out       (container_out),
    .container_out_valid (container_out_valid),
    .ready_in            (ready_in),
    .overflow_out        (overflow_out),
    .err_cnt             (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [3:0] opc, input logic [31:0] a, b, c, input logic [15:0] pg);
    action_in    = {opc, 21'h15A5A};
    operand_1_in = a;
    operand_2_in = b;
    operand_3_in = c;
    page_tbl_in  = pg;
    action_valid = 1'b1;
  endtask

  task automatic clear_inputs();
    action_valid = 1'b0;
    action_in    = '0;
    operand_1_in = '0;
    operand_2_in = '0;
    operand_3_in = '0;
    page_tbl_in  = '0;
  endtask

  // Issue one action from IDLE, wait (bounded) for the result; ready_in assumed 1.
  task automatic do_action(input logic [3:0] opc, input logic [31:0] a, b, c, input logic [15:0] pg,
                           output logic [31:0] r, output logic o, output int l);
    @(negedge clk);
    drive(opc, a, b, c, pg);
    @(negedge clk);
    clear_inputs();
    l = 1;
    while (!container_out_valid && l < 10) begin
      @(negedge clk);
      l++;
    end
    if (!container_out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: opcode %b got no valid within %0d cycles", opc, l);
    end
    r = container_out;
    o = overflow_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready_in = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
    checks++; if (container_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", container_out_valid); end
    checks++; if (container_out !== 32'h0) begin errors++; $display("FAIL reset_container: got %h expected 0", container_out); end
    checks++; if (err_cnt !== 16'h0 || overflow_out !== 1'b0) begin errors++; $display("FAIL reset_err: got cnt %h ovf %b expected 0 0", err_cnt, overflow_out); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    do_action(4'b0001, 32'd5, 32'd7, 32'd0, 16'h0000, res, ovf, lat);
    checks++; if (res !== 32'd12) begin errors++; $display("FAIL add_result: got %h expected %h", res, 32'd12); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_no_ovf: got %b expected 0", ovf); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL add_ready_in_out: got %b expected 0", ready_out); end
    do_action(4'b1001, 32'hFFFF_FFFF, 32'd2, 32'd0, 16'h0000, res, ovf, lat);
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL add_wrap: got %h expected 1", res); end
  endtask

  task automatic test_alu_ops();
    do_action(4'b1100, 32'hFFFF_FFF0, 32'h20, 32'd0, 16'h0, res, ovf, lat);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sadd_clamp: got %h expected ffffffff", res); end
    do_action(4'b1100, 32'd1, 32'd2, 32'd0, 16'h0, res, ovf, lat);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL sadd_plain: got %h expected 3", res); end
    do_action(4'b0010, 32'd3, 32'd5, 32'd0, 16'h0, res, ovf, lat);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_wrap: got %h expected fffffffe", res); end
    do_action(4'b1010, 32'd100, 32'd1, 32'd0, 16'h0, res, ovf, lat);
    checks++; if (res !== 32'd99) begin errors++; $display("FAIL sub_alt: got %h expected 63", res); end
    do_action(4'b0101, 32'hF0, 32'h0F, 32'd0, 16'h0, res, ovf, lat);
    checks++; if (res !== 32'hFF) begin errors++; $display("FAIL or: got %h expected ff", res); end
    do_action(4'b0110, 32'd5, 32'd5, 32'd9, 16'h0, res, ovf, lat);
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL geq_equal: got %h expected 1", res); end
    do_action(4'b0110, 32'd4, 32'd5, 32'd9, 16'h0, res, ovf, lat);
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL geq_less: got %h expected 0", res); end
    do_action(4'b1110, 32'd1, 32'h1234, 32'd9, 16'h0, res, ovf, lat);
    checks++; if (res !== 32'h1234) begin errors++; $display("FAIL set: got %h expected 1234", res); end
    do_action(4'b1101, 32'd1, 32'd2, 32'hC0DE, 16'h0, res, ovf, lat);
    checks++; if (res !== 32'hC0DE) begin errors++; $display("FAIL default_op: got %h expected c0de", res); end
  endtask

  task automatic test_store_loadd();
    do_action(4'b1000, 32'd41, 32'd2, 32'h77, 16'h0408, res, ovf, lat);
    checks++; if (res !== 32'h77) begin errors++; $display("FAIL store_result: got %h expected 77", res); end
    do_action(4'b0111, 32'd0, 32'd2, 32'd0, 16'h0408, res, ovf, lat);
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL loadd_result: got %0d expected 42", res); end
    do_action(4'b1011, 32'd0, 32'd2, 32'd0, 16'h0408, res, ovf, lat);
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL load_after_loadd: got %0d expected 42", res); end
    do_action(4'b1011, 32'd0, 32'd0, 32'd0, 16'h000A, res, ovf, lat);
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL ram10_direct: got %0d expected 42", res); end
    // base 30 + idx 3 wraps to word 1
    do_action(4'b0011, 32'hBEEF, 32'd3, 32'd0, 16'h1F1E, res, ovf, lat);
    do_action(4'b1011, 32'd0, 32'd0, 32'd0, 16'h1F01, res, ovf, lat);
    checks++; if (res !== 32'hBEEF) begin errors++; $display("FAIL base_wrap: got %h expected beef", res); end
  endtask

  task automatic test_wrapcnt();
    logic [31:0] exp_r [4] = '{32'd29, 32'd30, 32'd0, 32'd1};
    do_action(4'b1000, 32'd29, 32'd3, 32'd0, 16'h1F00, res, ovf, lat);
    for (int i = 0; i < 4; i++) begin
      do_action(4'b0100, 32'd0, 32'd3, 32'd30, 16'h1F00, res, ovf, lat);
      checks++; if (res !== exp_r[i]) begin errors++; $display("FAIL wrapcnt_%0d: got %0d expected %0d", i, res, exp_r[i]); end
    end
  endtask

  task automatic test_overflow();
    do_action(4'b1000, 32'h1234, 32'd5, 32'd0, 16'h1F00, res, ovf, lat);
    do_action(4'b1000, 32'h4444, 32'd4, 32'd0, 16'h1F00, res, ovf, lat);
    do_action(4'b1011, 32'd0, 32'd5, 32'hAB, 16'h0300, res, ovf, lat);
    checks++; if (res !== 32'hAB) begin errors++; $display("FAIL ovf_result: got %h expected ab", res); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL ovf_errcnt1: got %0d expected 1", err_cnt); end
    do_action(4'b1000, 32'h999, 32'd4, 32'hCD, 16'h0300, res, ovf, lat);
    checks++; if (res !== 32'hCD || ovf !== 1'b1) begin errors++; $display("FAIL ovf_store: got %h/%b expected cd/1", res, ovf); end
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL ovf_errcnt2: got %0d expected 2", err_cnt); end
    do_action(4'b1011, 32'd0, 32'd4, 32'd0, 16'h1F00, res, ovf, lat);
    checks++; if (res !== 32'h4444) begin errors++; $display("FAIL ovf_no_write: got %h expected 4444", res); end
    do_action(4'b1011, 32'd0, 32'd5, 32'hAB, 16'h0500, res, ovf, lat);
    checks++; if (res !== 32'h1234 || ovf !== 1'b0) begin errors++; $display("FAIL idx_eq_len: got %h/%b expected 1234/0", res, ovf); end
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL errcnt_hold: got %0d expected 2", err_cnt); end
  endtask

  task automatic test_backpressure();
    do_action(4'b1000, 32'h11, 32'd6, 32'd0, 16'h1F00, res, ovf, lat);
    @(negedge clk);
    ready_in = 1'b0;
    drive(4'b1000, 32'h22, 32'd6, 32'h33, 16'h1F00);
    @(negedge clk);
    drive(4'b1011, 32'd0, 32'd6, 32'h5A, 16'h1F00);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (container_out !== 32'h33 || container_out_valid !== 1'b1 || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got %h/%b/%b expected 33/1/0", i, container_out, container_out_valid, ready_out);
      end
      @(negedge clk);
    end
    clear_inputs();
    ready_in = 1'b1;
    @(negedge clk);
    checks++; if (container_out_valid !== 1'b0 || ready_out !== 1'b1) begin errors++; $display("FAIL bp_release: got valid %b ready %b expected 0 1", container_out_valid, ready_out); end
    repeat (3) @(negedge clk);
    checks++; if (container_out_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_action: got valid %b expected 0", container_out_valid); end
    do_action(4'b1011, 32'd0, 32'd6, 32'd0, 16'h1F00, res, ovf, lat);
    checks++; if (res !== 32'h22) begin errors++; $display("FAIL bp_write_done: got %h expected 22", res); end
  endtask

  task automatic test_reset_mid();
    do_action(4'b1000, 32'h55, 32'd9, 32'd0, 16'h1F00, res, ovf, lat);
    @(negedge clk);
    drive(4'b1000, 32'h99, 32'd9, 32'h1, 16'h1F00);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    checks++; if (ready_out !== 1'b1 || container_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got ready %b valid %b expected 1 0", ready_out, container_out_valid); end
    checks++; if (container_out !== 32'h0 || overflow_out !== 1'b0 || err_cnt !== 16'h0) begin errors++; $display("FAIL midrst_data: got %h/%b/%h expected 0/0/0", container_out, overflow_out, err_cnt); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_action(4'b1011, 32'd0, 32'd9, 32'd0, 16'h1F00, res, ovf, lat);
    checks++; if (res !== 32'h55) begin errors++; $display("FAIL midrst_no_write: got %h expected 55", res); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_store_loadd();
    test_wrapcnt();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stateful_alu.md
STATEFUL_ALU -- requirements
Module: stateful_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of operands, RAM words and result.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning state RAM depth of 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter ACTION_LEN, default 25, meaning action width; opcode = action_in[ACTION_LEN-1 -: 4].
REQ-004 SHALL have parameter ERR_CNT_WIDTH, default 16, meaning overflow error counter width.
REQ-005 SHALL have these ports; one clock; reset is asynchronous and active-high:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- action_in  in  ACTION_LEN  action word
- action_valid  in  1  action present
- operand_1_in, operand_2_in, operand_3_in  in  DATA_WIDTH each  operands
- page_tbl_in  in  16  {addr_len[15:8], base_addr[7:0]}, tenant window
- ready_out  out  1  block can accept an action
- container_out  out  DATA_WIDTH  result
- container_out_valid  out  1  result valid
- ready_in  in  1  downstream accepts result
- overflow_out  out  1  current result came from an out-of-window access
- err_cnt  out  ERR_CNT_WIDTH  count of out-of-window accesses

Function
REQ-006 SHALL be a 3-state FSM: IDLE, READ, OUT; ready_out = 1 only in IDLE.
REQ-007 SHALL accept an action when action_valid && ready_out; capture opcode, operands and page_tbl_in; IDLE->READ.
REQ-008 SHALL hold an inferred simple dual-port RAM, 2^ADDR_WIDTH x DATA_WIDTH, 1-cycle registered read; read address driven combinationally in the accept cycle.
REQ-009 SHALL form RAM address as (base_addr + operand_2_in[ADDR_WIDTH-1:0]) mod 2^ADDR_WIDTH; index = operand_2_in[ADDR_WIDTH-1:0].
REQ-010 SHALL flag overflow for RAM opcodes (1000, 0011, 1011, 0111, 0100) when index > addr_len; overflow: result = operand_3_in, no RAM write, overflow_out = 1 with the result, err_cnt += 1 saturating at all-ones.
REQ-011 SHALL compute results (all arithmetic mod 2^DATA_WIDTH, unsigned):
- 0001/1001 add: op1+op2
- 0010/1010 sub: op1-op2
- 1100 sadd: op1+op2, clamped to all-ones on carry
- 0101 or: bitwise op1|op2
- 0110 geq: 1 if op1>=op2 else 0
- 1110 set: op2
- 1000/0011 store: result op3; write RAM[addr] <= op1
- 1011 load: result RAM[addr]
- 0111 loadd: result RAM[addr]+1; write RAM[addr] <= RAM[addr]+1
- 0100 wrapcnt: result RAM[addr]; write RAM[addr] <= (RAM[addr]==op3) ? 0 : RAM[addr]+1
- any other: result op3, no write
REQ-012 SHALL go READ->OUT unconditionally, registering the result; container_out_valid = 1 in OUT.
REQ-013 SHALL hold container_out, container_out_valid and overflow_out stable in OUT while ready_in = 0.
REQ-014 SHALL, on the OUT cycle with ready_in = 1, perform the pending RAM write (if any, not overflow) at that clock edge and go OUT->IDLE; valid drops the following cycle.
REQ-015 SHALL give latency: accept cycle C0, valid from C2; minimum accept-to-accept period 3 cycles; next action's read observes the previous write.
REQ-016 SHALL ignore action_valid outside IDLE; action_in need not be held after acceptance.
REQ-017 SHALL compare index to addr_len as unsigned; addr_len >= 2^ADDR_WIDTH-1 never overflows; base wrap-around is legal.

Reset
REQ-018 SHALL on rst: FSM IDLE, ready_out = 1, container_out = 0, container_out_valid = 0, overflow_out = 0, err_cnt = 0.
REQ-019 SHALL on reset mid-operation discard the action with no RAM write; RAM contents not cleared by reset.

Verification
REQ-020 Add: op1=5, op2=7, opcode 0001 -> container_out=12 valid at C2; sadd 0xFFFFFFF0+0x20 -> 0xFFFFFFFF.
REQ-021 Store then loadd: page {4,8}, store op1=41 idx 2; loadd idx 2 -> result 42; load idx 2 -> 42; RAM[10]=42.
REQ-022 Wrapcnt: RAM word = 29, op3=30, four back-to-back wrapcnt actions -> results 29, 30, 0, 1.
REQ-023 Overflow: page {3,0}, load idx 5, op3=0xAB -> result 0xAB, overflow_out=1, err_cnt=1, no RAM change.
REQ-024 Backpressure: ready_in=0 for 5 cycles in OUT -> result held, ready_out=0, no write until handshake.
REQ-025 Reset asserted in READ during a store -> outputs at reset values, later load of that address returns old value.
